// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks one active-low column at a time, decodes a single
// pressed key per full scan, and debounces press/release over whole scans.
module keypad_scanner #(
    parameter int SCAN_TICKS     = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       CLK100MHZ,
    input  logic       RST,
    input  logic [3:0] ROW,
    output logic [3:0] COL,
    output logic [3:0] KEYVAL,
    output logic       KEYVALID,
    output logic       KEYPULSE,
    output logic [1:0] SCANSTATE
);

    localparam int TW = $clog2(SCAN_TICKS);
    localparam int NW = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } state_t;

    logic [3:0]    row_meta_q, row_sync_q;
    logic [TW-1:0] t_q;
    logic [1:0]    c_q;
    logic [1:0]    acc_cnt_q;
    logic [3:0]    acc_code_q;
    state_t        state_q, state_d;
    logic [NW-1:0] n_q, n_d;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    keyval_q, keyval_d;
    logic          valid_q, valid_d;
    logic          pulse_q, pulse_d;

    logic          sample, scan_end;
    logic [2:0]    col_lows, scan_lows;
    logic [1:0]    col_row;
    logic [3:0]    code_here, code_all;
    logic          key_hit;
    logic [NW-1:0] n_plus;

    function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
            4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
            4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
            4'hC: code = 4'h0;  4'hD: code = 4'hF;  4'hE: code = 4'hE;  default: code = 4'hD;
        endcase
        return code;
    endfunction

    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            row_meta_q <= 4'b1111;
            row_sync_q <= 4'b1111;
        end else begin
            row_meta_q <= ROW;
            row_sync_q <= row_meta_q;
        end
    end

    assign sample   = (t_q == TW'(SCAN_TICKS - 1));
    assign scan_end = sample && (c_q == 2'd3);

    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            t_q <= '0;
            c_q <= 2'd0;
        end else if (sample) begin
            t_q <= '0;
            c_q <= c_q + 2'd1;
        end else begin
            t_q <= t_q + TW'(1);
        end
    end

    assign COL = ~(4'b0001 << c_q);

    // Low rows in the column being sampled now; the last low row wins the index,
    // which only matters when exactly one is low.
    always_comb begin
        col_lows = 3'd0;
        col_row  = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (!row_sync_q[r]) begin
                col_lows = col_lows + 3'd1;
                col_row  = 2'(r);
            end
        end
    end

    assign code_here = keymap(col_row, c_q);
    assign scan_lows = {1'b0, acc_cnt_q} + col_lows;
    assign code_all  = (col_lows == 3'd1) ? code_here : acc_code_q;
    assign key_hit   = (scan_lows == 3'd1);

    // Accumulated low count saturates at 2: anything above one is already a reject.
    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            acc_cnt_q  <= 2'd0;
            acc_code_q <= 4'h0;
        end else if (scan_end) begin
            acc_cnt_q  <= 2'd0;
            acc_code_q <= 4'h0;
        end else if (sample) begin
            acc_cnt_q  <= (scan_lows > 3'd2) ? 2'd2 : scan_lows[1:0];
            acc_code_q <= code_all;
        end
    end

    assign n_plus = n_q + NW'(1);

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        cand_d   = cand_q;
        keyval_d = keyval_q;
        valid_d  = valid_q;
        pulse_d  = 1'b0;
        if (scan_end) begin
            case (state_q)
                IDLE: begin
                    if (key_hit) begin
                        cand_d  = code_all;
                        n_d     = NW'(1);
                        state_d = DB_PRESS;
                    end
                end
                DB_PRESS: begin
                    if (key_hit && code_all == cand_q) begin
                        if (n_plus == NW'(DEBOUNCE_SCANS)) begin
                            keyval_d = cand_q;
                            valid_d  = 1'b1;
                            pulse_d  = 1'b1;
                            n_d      = '0;
                            state_d  = HELD;
                        end else begin
                            n_d = n_plus;
                        end
                    end else begin
                        n_d     = '0;
                        state_d = IDLE;
                    end
                end
                HELD: begin
                    if (!key_hit) begin
                        n_d     = NW'(1);
                        state_d = DB_RELEASE;
                    end
                end
                default: begin
                    // A different key during release neither resets nor advances the count.
                    if (!key_hit) begin
                        if (n_plus == NW'(DEBOUNCE_SCANS)) begin
                            valid_d = 1'b0;
                            n_d     = '0;
                            state_d = IDLE;
                        end else begin
                            n_d = n_plus;
                        end
                    end else if (code_all == cand_q) begin
                        n_d     = '0;
                        state_d = HELD;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            state_q  <= IDLE;
            n_q      <= '0;
            cand_q   <= 4'h0;
            keyval_q <= 4'h0;
            valid_q  <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            cand_q   <= cand_d;
            keyval_q <= keyval_d;
            valid_q  <= valid_d;
            pulse_q  <= pulse_d;
        end
    end

    assign KEYVAL    = keyval_q;
    assign KEYVALID  = valid_q;
    assign KEYPULSE  = pulse_q;
    assign SCANSTATE = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a key-matrix model drives ROW from COL, expected key codes
// are queued as keys are pressed and matched against recorded KEYPULSE events.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] keyval;
    logic       keyvalid;
    logic       keypulse;
    logic [1:0] scanstate;

    logic [15:0] pressed = 16'h0;   // bit r*4+c = key at row r, column c
    logic [3:0]  exp_q[$];
    logic [3:0]  obs_val[$];
    int          obs_cyc[$];
    int          rd_idx = 0;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    keypad_scanner #(.SCAN_TICKS(4), .DEBOUNCE_SCANS(3)) dut (
        .CLK100MHZ(clk),
        .RST(rst),
        .ROW(row),
        .COL(col),
        .KEYVAL(keyval),
        .KEYVALID(keyvalid),
        .KEYPULSE(keypulse),
        .SCANSTATE(scanstate)
    );

    always #5 clk = ~clk;

    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            row[r] = ~|(pressed[r*4 +: 4] & ~col);
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (keypulse) begin
            obs_val.push_back(keyval);
            obs_cyc.push_back(cyc);
        end
    end

    // Leaves the bench on the first cycle of a scan (column 0, tick 0).
    task automatic align_scan();
        int n = 0;
        while (col !== 4'b0111 && n < 40) begin @(negedge clk); n++; end
        while (col !== 4'b1110 && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) begin
            checks++; errors++;
            $display("FAIL align_scan COL=%b required=1110 within 40 cycles", col);
        end
    endtask

    task automatic wait_scans(input int s);
        repeat (s * 16) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks += 5;
        if (col !== 4'b1110) begin errors++; $display("FAIL reset_col COL=%b required=1110", col); end
        if (keyval !== 4'h0) begin errors++; $display("FAIL reset_keyval KEYVAL=%h required=0", keyval); end
        if (keyvalid !== 1'b0) begin errors++; $display("FAIL reset_keyvalid KEYVALID=%b required=0", keyvalid); end
        if (keypulse !== 1'b0) begin errors++; $display("FAIL reset_keypulse KEYPULSE=%b required=0", keypulse); end
        if (scanstate !== 2'd0) begin errors++; $display("FAIL reset_state SCANSTATE=%0d required=0", scanstate); end
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            exp_col = 4'b0001 << (k / 4);
            exp_col = ~exp_col;
            checks++;
            if (col !== exp_col) begin
                errors++; $display("FAIL col_walk cycle=%0d COL=%b required=%b", k, col, exp_col);
            end
            @(negedge clk);
        end
        $display("test_reset done: errors=%0d", errors);
    endtask

    task automatic test_press_release();
        int c0;
        align_scan();
        c0 = cyc;
        exp_q.push_back(4'h5);
        pressed[1*4+1] = 1'b1;
        repeat (47) @(negedge clk);
        checks++;
        if (keyvalid !== 1'b0) begin errors++; $display("FAIL press5_early KEYVALID=%b required=0 at cycle 47", keyvalid); end
        @(negedge clk);
        checks += 3;
        if (keypulse !== 1'b1) begin errors++; $display("FAIL press5_pulse KEYPULSE=%b required=1 at cycle 48", keypulse); end
        if (keyvalid !== 1'b1) begin errors++; $display("FAIL press5_valid KEYVALID=%b required=1", keyvalid); end
        if (keyval !== 4'h5) begin errors++; $display("FAIL press5_keyval KEYVAL=%h required=5", keyval); end
        @(negedge clk);
        checks++;
        if (keypulse !== 1'b0) begin errors++; $display("FAIL press5_pulse_width KEYPULSE=%b required=0", keypulse); end
        while (rd_idx < obs_val.size()) begin
            checks += 2;
            if (exp_q.size() == 0) begin errors += 2; $display("FAIL press5_sb unexpected pulse KEYVAL=%h", obs_val[rd_idx]); end
            else begin
                if (obs_val[rd_idx] !== exp_q[0]) begin errors++; $display("FAIL press5_sb KEYVAL=%h required=%h", obs_val[rd_idx], exp_q[0]); end
                if (obs_cyc[rd_idx] != c0 + 48) begin errors++; $display("FAIL press5_latency cycle=%0d required=%0d", obs_cyc[rd_idx] - c0, 48); end
                void'(exp_q.pop_front());
            end
            rd_idx++;
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL press5_sb missing=%0d pulses required=0", exp_q.size()); exp_q.delete(); end
        wait_scans(2);
        align_scan();
        pressed[1*4+1] = 1'b0;
        repeat (47) @(negedge clk);
        checks++;
        if (keyvalid !== 1'b1) begin errors++; $display("FAIL release5_early KEYVALID=%b required=1 at cycle 47", keyvalid); end
        @(negedge clk);
        checks += 3;
        if (keyvalid !== 1'b0) begin errors++; $display("FAIL release5_valid KEYVALID=%b required=0 at cycle 48", keyvalid); end
        if (keyval !== 4'h5) begin errors++; $display("FAIL release5_keyval KEYVAL=%h required=5", keyval); end
        if (obs_val.size() != rd_idx) begin errors++; $display("FAIL release5_pulse pulses=%0d required=0", obs_val.size() - rd_idx); rd_idx = obs_val.size(); end
        $display("test_press_release done: errors=%0d", errors);
    endtask

    task automatic test_bounce();
        align_scan();
        exp_q.push_back(4'h7);
        for (int i = 0; i < 32; i++) begin
            if (i % 5 == 0) pressed[2*4+0] = ~pressed[2*4+0];
            @(negedge clk);
        end
        pressed[2*4+0] = 1'b1;
        wait_scans(6);
        while (rd_idx < obs_val.size()) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL bounce_sb unexpected pulse KEYVAL=%h", obs_val[rd_idx]); end
            else if (obs_val[rd_idx] !== exp_q.pop_front()) begin errors++; $display("FAIL bounce_sb KEYVAL=%h required=7", obs_val[rd_idx]); end
            rd_idx++;
        end
        checks += 3;
        if (exp_q.size() != 0) begin errors++; $display("FAIL bounce_sb missing=%0d pulses required=0", exp_q.size()); exp_q.delete(); end
        if (keyval !== 4'h7) begin errors++; $display("FAIL bounce_keyval KEYVAL=%h required=7", keyval); end
        if (keyvalid !== 1'b1) begin errors++; $display("FAIL bounce_valid KEYVALID=%b required=1", keyvalid); end
        pressed[2*4+0] = 1'b0;
        wait_scans(4);
        checks++;
        if (keyvalid !== 1'b0) begin errors++; $display("FAIL bounce_release KEYVALID=%b required=0", keyvalid); end
        $display("test_bounce done: errors=%0d", errors);
    endtask

    task automatic test_multi_key();
        logic bad_state = 1'b0;
        logic bad_valid = 1'b0;
        align_scan();
        pressed[0] = 1'b1;
        pressed[1] = 1'b1;
        repeat (160) begin
            @(negedge clk);
            if (scanstate !== 2'd0) bad_state = 1'b1;
            if (keyvalid !== 1'b0) bad_valid = 1'b1;
        end
        checks += 3;
        if (bad_state) begin errors++; $display("FAIL multi_state SCANSTATE left 0 required=0 throughout"); end
        if (bad_valid) begin errors++; $display("FAIL multi_valid KEYVALID went 1 required=0 throughout"); end
        if (obs_val.size() != rd_idx) begin errors++; $display("FAIL multi_pulse pulses=%0d required=0", obs_val.size() - rd_idx); rd_idx = obs_val.size(); end
        align_scan();
        exp_q.push_back(4'h1);
        pressed[1] = 1'b0;
        wait_scans(4);
        while (rd_idx < obs_val.size()) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL multi_sb unexpected pulse KEYVAL=%h", obs_val[rd_idx]); end
            else if (obs_val[rd_idx] !== exp_q.pop_front()) begin errors++; $display("FAIL multi_sb KEYVAL=%h required=1", obs_val[rd_idx]); end
            rd_idx++;
        end
        checks += 2;
        if (exp_q.size() != 0) begin errors++; $display("FAIL multi_sb missing=%0d pulses required=0", exp_q.size()); exp_q.delete(); end
        if (keyval !== 4'h1) begin errors++; $display("FAIL multi_keyval KEYVAL=%h required=1", keyval); end
        pressed[0] = 1'b0;
        wait_scans(4);
        $display("test_multi_key done: errors=%0d", errors);
    endtask

    task automatic test_rollover();
        logic bad = 1'b0;
        align_scan();
        exp_q.push_back(4'h3);
        pressed[0*4+2] = 1'b1;
        wait_scans(4);
        align_scan();
        pressed[0*4+3] = 1'b1;
        repeat (16) @(negedge clk);
        checks++;
        if (scanstate !== 2'd3) begin errors++; $display("FAIL roll_state SCANSTATE=%0d required=3", scanstate); end
        pressed[0*4+2] = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (scanstate !== 2'd3 || keyvalid !== 1'b1 || keypulse !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL roll_hold state/valid/pulse changed required SCANSTATE=3 KEYVALID=1 KEYPULSE=0"); end
        pressed[0*4+3] = 1'b0;
        wait_scans(4);
        checks += 2;
        if (keyvalid !== 1'b0) begin errors++; $display("FAIL roll_release KEYVALID=%b required=0", keyvalid); end
        if (keyval !== 4'h3) begin errors++; $display("FAIL roll_keyval KEYVAL=%h required=3", keyval); end
        align_scan();
        exp_q.push_back(4'hA);
        pressed[0*4+3] = 1'b1;
        wait_scans(4);
        while (rd_idx < obs_val.size()) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL roll_sb unexpected pulse KEYVAL=%h", obs_val[rd_idx]); end
            else if (obs_val[rd_idx] !== exp_q[0]) begin errors++; $display("FAIL roll_sb KEYVAL=%h required=%h", obs_val[rd_idx], exp_q.pop_front()); end
            else void'(exp_q.pop_front());
            rd_idx++;
        end
        checks += 2;
        if (exp_q.size() != 0) begin errors++; $display("FAIL roll_sb missing=%0d pulses required=0", exp_q.size()); exp_q.delete(); end
        if (keyval !== 4'hA) begin errors++; $display("FAIL roll_keyval_a KEYVAL=%h required=a", keyval); end
        pressed[0*4+3] = 1'b0;
        wait_scans(4);
        $display("test_rollover done: errors=%0d", errors);
    endtask

    task automatic test_reset_mid_debounce();
        int c0;
        align_scan();
        pressed[3*4+3] = 1'b1;
        repeat (37) @(negedge clk);
        checks++;
        if (scanstate !== 2'd1) begin errors++; $display("FAIL mid_state SCANSTATE=%0d required=1", scanstate); end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks += 5;
        if (col !== 4'b1110) begin errors++; $display("FAIL mid_reset_col COL=%b required=1110", col); end
        if (keyval !== 4'h0) begin errors++; $display("FAIL mid_reset_keyval KEYVAL=%h required=0", keyval); end
        if (keyvalid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid KEYVALID=%b required=0", keyvalid); end
        if (keypulse !== 1'b0) begin errors++; $display("FAIL mid_reset_pulse KEYPULSE=%b required=0", keypulse); end
        if (scanstate !== 2'd0) begin errors++; $display("FAIL mid_reset_state SCANSTATE=%0d required=0", scanstate); end
        rst = 1'b0;
        c0 = cyc;
        exp_q.push_back(4'hD);
        repeat (47) @(negedge clk);
        checks++;
        if (keypulse !== 1'b0) begin errors++; $display("FAIL mid_early_pulse KEYPULSE=%b required=0 at cycle 47", keypulse); end
        @(negedge clk);
        checks += 2;
        if (keypulse !== 1'b1) begin errors++; $display("FAIL mid_pulse KEYPULSE=%b required=1 at cycle 48", keypulse); end
        if (keyval !== 4'hD) begin errors++; $display("FAIL mid_keyval KEYVAL=%h required=d", keyval); end
        @(negedge clk);
        while (rd_idx < obs_val.size()) begin
            checks += 2;
            if (exp_q.size() == 0) begin errors += 2; $display("FAIL mid_sb unexpected pulse KEYVAL=%h", obs_val[rd_idx]); end
            else begin
                if (obs_val[rd_idx] !== exp_q[0]) begin errors++; $display("FAIL mid_sb KEYVAL=%h required=%h", obs_val[rd_idx], exp_q[0]); end
                if (obs_cyc[rd_idx] != c0 + 48) begin errors++; $display("FAIL mid_latency cycle=%0d required=48", obs_cyc[rd_idx] - c0); end
                void'(exp_q.pop_front());
            end
            rd_idx++;
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL mid_sb missing=%0d pulses required=0", exp_q.size()); exp_q.delete(); end
        pressed[3*4+3] = 1'b0;
        wait_scans(4);
        $display("test_reset_mid_debounce done: errors=%0d", errors);
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_bounce();
        test_multi_key();
        test_rollover();
        test_reset_mid_debounce();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
